// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (I) and data access (D)
module mem_port_arbiter #(
    parameter bit          FAIR    = 1'b1,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready_n,
    output logic        timeout
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] I_BUSY  = 2'd1;
    localparam logic [1:0] D_BUSY  = 2'd2;
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        last_d_q;
    logic [31:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;
    logic [1:0]  size_q;
    logic        write_q, i_done_q, d_done_q, timeout_q;
    logic        i_req_e, d_req_e, grant_d, grant_i, busy, ready, abort, finish;

    // Arbitration and completion decode; a requester whose done is pulsing still holds
    // its req this cycle, so it is masked to avoid an immediate re-grant.
    always_comb begin
        i_req_e = i_req & ~i_done_q;
        d_req_e = d_req & ~d_done_q;
        grant_d = (state_q == IDLE) & d_req_e & (~i_req_e | ~FAIR | ~last_d_q);
        grant_i = (state_q == IDLE) & i_req_e & ~grant_d;
        busy    = state_q != IDLE;
        ready   = busy & ~mem_ready_n;
        abort   = busy & mem_ready_n & (TIMEOUT != 0) & (cnt_q == TO_LAST);
        finish  = ready | abort;
        state_d = grant_d ? D_BUSY : grant_i ? I_BUSY : finish ? IDLE : state_q;
        cnt_d   = busy ? cnt_q + {9'd0, mem_ready_n} : 10'd0;
    end

    // State, request latch on grant, result capture and done/timeout pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 10'd0;
            last_d_q  <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            size_q    <= 2'b00;
            write_q   <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            i_done_q  <= finish & (state_q == I_BUSY);
            d_done_q  <= finish & (state_q == D_BUSY);
            timeout_q <= abort;
            if (grant_d | grant_i) begin
                last_d_q <= grant_d;
                addr_q   <= grant_d ? d_addr : i_addr;
                size_q   <= grant_d ? d_size : 2'b00;
                write_q  <= grant_d & d_write;
                wdata_q  <= grant_d ? d_wdata : 32'd0;
            end
            if (finish & (state_q == I_BUSY))
                i_rdata_q <= ready ? mem_rdata : 32'd0;
            if (finish & (state_q == D_BUSY))
                d_rdata_q <= (ready & ~write_q) ? mem_rdata : 32'd0;
        end
    end

    assign mem_req   = busy;
    assign mem_write = write_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign timeout   = timeout_q;
    assign i_stall   = i_req & ~i_done_q;
    assign d_stall   = d_req & ~d_done_q;
endmodule
